// File: rtl/palette_encoder.sv
// palette_encoder: nearest-colour search over a writable RGB palette table.
// A colour accepted in IDLE is compared against one table entry per clock;
// the index and Manhattan distance of the nearest entry are presented in DONE
// until the consumer takes them.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and out_index/out_dist are held stable for as long as out_valid stays high.
module palette_encoder #(
   parameter int NUM_ENTRIES = 16,
   parameter int IDX_W       = 4,
   parameter int COLOR_W     = 8
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     wr_addr,
   input  logic [3*COLOR_W-1:0] wr_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [COLOR_W-1:0]   in_R,
   input  logic [COLOR_W-1:0]   in_G,
   input  logic [COLOR_W-1:0]   in_B,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [IDX_W-1:0]     out_index,
   output logic [COLOR_W+1:0]   out_dist,
   output logic                 busy,
   output logic [1:0]           state_dbg
);

   localparam int DIST_W = COLOR_W + 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [3*COLOR_W-1:0]   tbl_q [NUM_ENTRIES];
   logic [3*COLOR_W-1:0]   tbl_d [NUM_ENTRIES];
   logic [3*COLOR_W-1:0]   rgb_q, rgb_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [IDX_W-1:0]       best_idx_q, best_idx_d;
   logic [DIST_W-1:0]      best_dist_q, best_dist_d;
   logic [IDX_W-1:0]       out_index_q, out_index_d;
   logic [DIST_W-1:0]      out_dist_q, out_dist_d;
   logic                   out_valid_q, out_valid_d;
   logic                   in_ready_q, in_ready_d;
   logic                   busy_q, busy_d;

   logic [3*COLOR_W-1:0]   entry;
   logic [DIST_W-1:0]      cur_dist;
   logic [DIST_W-1:0]      upd_dist;
   logic [IDX_W-1:0]       upd_idx;

   function automatic logic [COLOR_W-1:0] abs_diff(input logic [COLOR_W-1:0] a,
                                                    input logic [COLOR_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   // Distance from the latched colour to the entry under comparison (pre-write table value).
   always_comb begin
      entry    = tbl_q[idx_q];
      cur_dist = DIST_W'(abs_diff(rgb_q[3*COLOR_W-1:2*COLOR_W], entry[3*COLOR_W-1:2*COLOR_W]))
               + DIST_W'(abs_diff(rgb_q[2*COLOR_W-1:COLOR_W],   entry[2*COLOR_W-1:COLOR_W]))
               + DIST_W'(abs_diff(rgb_q[COLOR_W-1:0],           entry[COLOR_W-1:0]));
   end

   // Next-state logic: table writes, search sequencing and registered outputs.
   always_comb begin
      state_d     = state_q;
      tbl_d       = tbl_q;
      rgb_d       = rgb_q;
      idx_d       = idx_q;
      best_idx_d  = best_idx_q;
      best_dist_d = best_dist_q;
      out_index_d = out_index_q;
      out_dist_d  = out_dist_q;
      upd_dist    = best_dist_q;
      upd_idx     = best_idx_q;

      // Writes land at the edge, so the running comparison still sees the old value.
      if (wr_en && (32'(wr_addr) < NUM_ENTRIES)) begin
         tbl_d[wr_addr] = wr_data;
      end

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               rgb_d       = {in_R, in_G, in_B};
               idx_d       = '0;
               best_idx_d  = '0;
               best_dist_d = '1;
               state_d     = SEARCH;
            end
         end
         SEARCH: begin
            // Strict less-than keeps the lower index on ties.
            if (cur_dist < best_dist_q) begin
               upd_dist = cur_dist;
               upd_idx  = idx_q;
            end
            best_dist_d = upd_dist;
            best_idx_d  = upd_idx;
            if ((cur_dist == '0) || (idx_q == LAST_IDX)) begin
               out_index_d = upd_idx;
               out_dist_d  = upd_dist;
               state_d     = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      out_valid_d = (state_d == DONE);
      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   // State and table registers; reset clears the table and drops any search.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q     <= IDLE;
         tbl_q       <= '{default: '0};
         rgb_q       <= '0;
         idx_q       <= '0;
         best_idx_q  <= '0;
         best_dist_q <= '1;
         out_index_q <= '0;
         out_dist_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tbl_q       <= tbl_d;
         rgb_q       <= rgb_d;
         idx_q       <= idx_d;
         best_idx_q  <= best_idx_d;
         best_dist_q <= best_dist_d;
         out_index_q <= out_index_d;
         out_dist_q  <= out_dist_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_index = out_index_q;
   assign out_dist  = out_dist_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_palette_encoder.sv
// Directed bench for palette_encoder with an expected-result queue.
module tb_palette_encoder;

   localparam int NUM_ENTRIES = 16;
   localparam int IDX_W       = 4;
   localparam int COLOR_W     = 8;
   localparam int DIST_W      = COLOR_W + 2;
   localparam int RES_W       = IDX_W + DIST_W;

   logic                 Clk;
   logic                 Reset;
   logic                 wr_en;
   logic [IDX_W-1:0]     wr_addr;
   logic [3*COLOR_W-1:0] wr_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [COLOR_W-1:0]   in_R, in_G, in_B;
   logic                 out_valid;
   logic                 out_ready;
   logic [IDX_W-1:0]     out_index;
   logic [DIST_W-1:0]    out_dist;
   logic                 busy;
   logic [1:0]           state_dbg;

   logic [RES_W-1:0]     exp_q[$];
   int                   tests;
   int                   fails;
   int                   cyc_g;

   palette_encoder #(
      .NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W), .COLOR_W(COLOR_W)
   ) dut (
      .Clk(Clk), .Reset(Reset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_R(in_R), .in_G(in_G), .in_B(in_B),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_index(out_index), .out_dist(out_dist),
      .busy(busy), .state_dbg(state_dbg)
   );

   // Clock
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge; all driving and sampling happens there.
   task automatic step();
      @(negedge Clk);
      cyc_g++;
   endtask

   task automatic write_entry(input int addr, input logic [3*COLOR_W-1:0] data);
      wr_en   = 1'b1;
      wr_addr = IDX_W'(addr);
      wr_data = data;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic fill_table(input logic [3*COLOR_W-1:0] data);
      for (int i = 0; i < NUM_ENTRIES; i++) write_entry(i, data);
   endtask

   // Offer a colour; returns at the falling edge after the accepting edge E0.
   task automatic start_colour(input logic [3*COLOR_W-1:0] rgb,
                               input logic [IDX_W-1:0] e_idx, input logic [DIST_W-1:0] e_dist);
      check("accept_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      {in_R, in_G, in_B} = rgb;
      exp_q.push_back({e_idx, e_dist});
      step();
      in_valid = 1'b0;
      cyc_g = 0;
   endtask

   task automatic wait_result(input string tag, input int lat);
      logic [RES_W-1:0] e;
      while (!out_valid && cyc_g < 64) step();
      check({tag, "_timeout"}, 32'(out_valid), 32'd1);
      check({tag, "_latency"}, 32'(cyc_g), 32'(lat));
      if (exp_q.size() == 0) begin
         check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_index"}, 32'(out_index), 32'(e[RES_W-1:DIST_W]));
         check({tag, "_dist"},  32'(out_dist),  32'(e[DIST_W-1:0]));
      end
   endtask

   task automatic handoff(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_ho_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_ho_ready"}, 32'(in_ready),  32'd1);
      check({tag, "_ho_busy"},  32'(busy),      32'd0);
   endtask

   initial begin
      tests = 0; fails = 0; cyc_g = 0;
      Reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      in_valid = 1'b0; in_R = '0; in_G = '0; in_B = '0; out_ready = 1'b0;
      step(); step();
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_out_index", 32'(out_index), 32'd0);
      check("rst_out_dist",  32'(out_dist),  32'd0);
      check("rst_state",     32'(state_dbg), 32'd0);
      Reset = 1'b1;
      step();

      // Cleared table: black matches entry 0 on the first compare.
      start_colour(24'h000000, 4'd0, 10'h000);
      check("zero_busy", 32'(busy), 32'd1);
      wait_result("zero", 1);
      handoff("zero");

      // Exact match at entry 3, then backpressure in DONE.
      write_entry(3, 24'hFFFFFF);
      start_colour(24'hFFFFFF, 4'd3, 10'h000);
      wait_result("exact", 4);
      in_valid = 1'b1;
      {in_R, in_G, in_B} = 24'h123456;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_valid",    32'(out_valid), 32'd1);
         check("bp_index",    32'(out_index), 32'd3);
         check("bp_dist",     32'(out_dist),  32'd0);
         check("bp_in_ready", 32'(in_ready),  32'd0);
         check("bp_busy",     32'(busy),      32'd1);
      end
      in_valid = 1'b0;
      handoff("bp");

      // Tie between entries 2 and 5 resolves to the lower index.
      fill_table(24'hFFFFFF);
      write_entry(2, 24'h200000);
      write_entry(5, 24'h000020);
      start_colour(24'h100010, 4'd2, 10'h020);
      wait_result("tie", 16);
      handoff("tie");

      // Write to a not-yet-compared entry is used by the running search.
      fill_table(24'hFFFFFF);
      start_colour(24'h000001, 4'd15, 10'h000);
      step(); step(); step();
      check("wr15_state", 32'(state_dbg), 32'd1);
      write_entry(15, 24'h000001);
      wait_result("wr15", 16);
      handoff("wr15");

      // Write to an already-compared entry does not affect the running search.
      write_entry(15, 24'hFFFFFF);
      start_colour(24'h000001, 4'd0, 10'h2FC);
      step(); step(); step();
      write_entry(2, 24'h000001);
      wait_result("wr2", 16);
      handoff("wr2");

      // Reset mid-search drops the search and clears the table.
      write_entry(2, 24'hFFFFFF);
      start_colour(24'h000001, 4'd0, 10'h2FC);
      for (int i = 0; i < 7; i++) step();
      check("mid_state_search", 32'(state_dbg), 32'd1);
      Reset = 1'b0;
      step();
      void'(exp_q.pop_back());
      check("mid_rst_state", 32'(state_dbg), 32'd0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy",  32'(busy),      32'd0);
      check("mid_rst_ready", 32'(in_ready),  32'd1);
      Reset = 1'b1;
      step();
      start_colour(24'h123456, 4'd0, 10'h09C);
      wait_result("post_rst", 16);
      handoff("post_rst");

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
